// File: rtl/md5_padder.sv
// MD5 message front end: packs an incoming byte stream into 512-bit blocks,
// applies MD5 padding (0x80 marker, zero fill, 64-bit little-endian bit
// length), sequences the blocks into md5_core and latches the final hash.
module md5_padder (
  input  logic         clk,
  input  logic         h_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic [0:511] blk_data,
  output logic         blk_start,
  output logic         blk_next,
  input  logic         core_done,
  input  logic [0:127] core_hash,
  output logic [0:127] digest,
  output logic         msg_done,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_ISSUE,
    S_WAIT,
    S_XPAD,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [0:511] buf_q, buf_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [60:0]  len_q, len_d;
  logic         first_q, first_d;
  logic         fin_q, fin_d;
  logic         pend_q, pend_d;
  logic         wfirst_q, wfirst_d;
  logic         busy_q, busy_d;
  logic [0:127] digest_q, digest_d;

  logic [63:0]  bit_len;
  logic [0:63]  len_le;
  logic [8:0]   wr_pos;

  // Message length in bits, byte-reversed so byte 56 of the block carries the LSB
  assign bit_len = {len_q, 3'b000};
  assign len_le  = {bit_len[7:0],   bit_len[15:8],  bit_len[23:16], bit_len[31:24],
                    bit_len[39:32], bit_len[47:40], bit_len[55:48], bit_len[63:56]};
  assign wr_pos  = {cnt_q[5:0], 3'b000};

  // Next-state logic: byte capture, padding steps and block hand-off to the core
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    first_d  = first_q;
    fin_d    = fin_q;
    pend_d   = pend_q;
    wfirst_d = wfirst_q;
    busy_d   = busy_q;
    digest_d = digest_q;
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          buf_d[wr_pos +: 8] = in_data;
          cnt_d  = cnt_q + 7'd1;
          len_d  = len_q + 61'd1;
          busy_d = 1'b1;
          if (in_last) begin
            state_d = S_PAD;
          end else if (cnt_q == 7'd63) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_PAD: begin
        if (cnt_q < 7'd64) begin
          buf_d[wr_pos +: 8] = 8'h80;
        end
        if (cnt_q <= 7'd55) begin
          buf_d[448:511] = len_le;
          fin_d = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        first_d  = 1'b0;
        wfirst_d = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wfirst_d = 1'b0;
        if (!wfirst_q && core_done) begin
          if (fin_q) begin
            state_d = S_DONE;
          end else if (pend_q) begin
            state_d = S_XPAD;
          end else begin
            buf_d   = '0;
            cnt_d   = 7'd0;
            state_d = S_FILL;
          end
        end
      end
      S_XPAD: begin
        buf_d = '0;
        if (cnt_q == 7'd64) begin
          buf_d[0:7] = 8'h80;
        end
        buf_d[448:511] = len_le;
        fin_d   = 1'b1;
        pend_d  = 1'b0;
        state_d = S_ISSUE;
      end
      S_DONE: begin
        digest_d = core_hash;
        buf_d    = '0;
        cnt_d    = 7'd0;
        len_d    = 61'd0;
        busy_d   = 1'b0;
        first_d  = 1'b1;
        fin_d    = 1'b0;
        pend_d   = 1'b0;
        state_d  = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  // State register with synchronous reset that abandons any message in flight
  always_ff @(posedge clk) begin
    if (h_rst) begin
      state_q  <= S_FILL;
      buf_q    <= '0;
      cnt_q    <= 7'd0;
      len_q    <= 61'd0;
      first_q  <= 1'b1;
      fin_q    <= 1'b0;
      pend_q   <= 1'b0;
      wfirst_q <= 1'b0;
      busy_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      first_q  <= first_d;
      fin_q    <= fin_d;
      pend_q   <= pend_d;
      wfirst_q <= wfirst_d;
      busy_q   <= busy_d;
      digest_q <= digest_d;
    end
  end

  assign in_ready  = (state_q == S_FILL) && !h_rst;
  assign blk_start = (state_q == S_ISSUE) && first_q;
  assign blk_next  = (state_q == S_ISSUE) && !first_q;
  assign msg_done  = (state_q == S_DONE);
  assign blk_data  = buf_q;
  assign digest    = digest_q;
  assign busy      = busy_q;

endmodule
